// File: rtl/sim_uart_pkg.sv
// Shared constants and state encoding for the simulation UART line arbiter.
package sim_uart_pkg;

    localparam logic [7:0] CR = 8'h0d;
    localparam logic [7:0] LF = 8'h0a;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sim_uart_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, as a one-hot grant.
// Purely combinational; ptr must stay below N.
module sim_uart_rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    // Walk from the farthest slot back towards ptr so the nearest valid one wins.
    always_comb begin
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % N]) begin
                grant = '0;
                grant[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/sim_uart_line_arb.sv
// Line-atomic arbiter of NREQ byte streams onto one registered byte output (1-cycle latency, held until out_ready).
// A grant lasts until CR/LF or MAXLEN bytes; SIM_UART_ARB_TIMEOUT_EN adds an idle-timeout release.
module sim_uart_line_arb
    import sim_uart_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int MAXLEN  = 256,
    parameter int TIMEOUT = 1024,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              theclk,
    input  logic              theresetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IW-1:0]     out_src,
    output logic              out_eol,
    output logic              busy
);

    localparam int CW = $clog2(MAXLEN + 1);

    arb_state_t      state;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] pick;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            can_take;
    logic            gvalid;
    logic [7:0]      gdata;
    logic            accept;
    logic            is_term;
    logic            at_max;
    logic            release_line;
    logic            timeout;
    logic [IW-1:0]   next_ptr;

    sim_uart_rr_pick #(.N(NREQ), .PW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick),
        .any   (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    assign can_take     = ~out_valid | out_ready;
    assign gvalid       = req_valid[grant];
    assign gdata        = req_data[8*int'(grant) +: 8];
    assign accept       = (state == LOCKED) & gvalid & can_take;
    assign is_term      = (gdata == CR) | (gdata == LF);
    assign at_max       = (cnt == CW'(MAXLEN - 1));
    assign release_line = accept & (is_term | at_max);
    assign next_ptr     = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
    assign busy         = (state == LOCKED);

    always_comb begin
        req_ready = '0;
        if (state == LOCKED) req_ready[grant] = can_take;
    end

`ifdef SIM_UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;
    logic          idle_cyc;

    // Only a fully drained, silent grant counts towards the timeout.
    assign idle_cyc = (state == LOCKED) & ~gvalid & ~out_valid;
    assign timeout  = idle_cyc & (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            idle_cnt <= '0;
        end else if (!idle_cyc || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_eol   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_src   <= grant;
                out_eol   <= is_term | at_max;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (release_line || timeout) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                        cnt   <= '0;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
